// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 bus writer and upstream sequencers.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package lcd1602_pkg;

  // FSM state encoding for the bus writer.
  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SETUP = 3'd2,
    ST_PULSE = 3'd3,
    ST_HOLD  = 3'd4,
    ST_EXEC  = 3'd5
  } lcd_state_t;

  // HD44780 command bytes used by sequencers.
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) commands need the long
  // execution wait. Character data with the same codes does not, and
  // 0x00 as a command is handled as an ordinary command.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] dat);
    return !rs && (dat[7:2] == 6'd0) && (dat[1:0] != 2'd0);
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter used to time every FSM state of the bus writer.
// Latency: load takes effect on the next edge; done is combinational (cnt == 0).
// Backpressure: none; counts down to zero and holds there until reloaded.
//   clk   : system clock
//   rst   : synchronous active-high reset, reloads RST_VAL
//   load  : load value on the next edge (has priority over counting)
//   value : count to load
//   done  : counter is at zero
module lcd_delay_cnt #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd1602_bus_writer.sv
// HD44780/LCD1602 byte writer: power-up wait, then RS/DB setup, E pulse, hold and execution wait per byte.
// Latency: lcd_dat/lcd_rs 1 cycle after transfer; lcd_en rises T_SETUP_CYC later; in_ready back after setup+pulse+hold+exec.
// Backpressure: in_ready low whenever not idle; in_valid ignored while busy, no skid buffer.
//   clk, rst            : system clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake, one {in_rs, in_data} per transfer
//   busy                : ~in_ready
//   lcd_rs/lcd_rw/lcd_en/lcd_dat : LCD pins (lcd_rw tied low, write only)
module lcd1602_bus_writer
  import lcd1602_pkg::*;
#(
  parameter int T_POWERUP_CYC = 2_000_000,
  parameter int T_SETUP_CYC   = 3,
  parameter int T_EPW_CYC     = 25,
  parameter int T_HOLD_CYC    = 2,
  parameter int T_EXEC_CYC    = 2_500,
  parameter int T_CLEAR_CYC   = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_dat
);

  localparam int T_MAX = max_int(max_int(max_int(T_POWERUP_CYC, T_SETUP_CYC),
                                         max_int(T_EPW_CYC, T_HOLD_CYC)),
                                 max_int(T_EXEC_CYC, T_CLEAR_CYC));
  localparam int CNT_W = $clog2(T_MAX) + 1;

  // A state of length N is entered with the counter loaded to N-1 and is left
  // on the edge where the counter reads zero, so it lasts exactly N cycles.
  localparam logic [CNT_W-1:0] L_POWERUP = CNT_W'(T_POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_SETUP   = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_EPW     = CNT_W'(T_EPW_CYC - 1);
  localparam logic [CNT_W-1:0] L_HOLD    = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] L_EXEC    = CNT_W'(T_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] L_CLEAR   = CNT_W'(T_CLEAR_CYC - 1);

  lcd_state_t       state;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_done;

  // The counter resets straight to the power-up length, so PWRUP needs no
  // explicit load and restarts in full on every reset.
  lcd_delay_cnt #(
    .W       (CNT_W),
    .RST_VAL (L_POWERUP)
  ) u_delay (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .value (cnt_value),
    .done  (cnt_done)
  );

  // Counter reload for the state being entered. PWRUP->IDLE and EXEC->IDLE
  // need none: the counter is already at zero and IDLE is untimed.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          cnt_load  = 1'b1;
          cnt_value = L_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          cnt_load  = 1'b1;
          cnt_value = L_EPW;
        end
      end
      ST_PULSE: begin
        if (cnt_done) begin
          cnt_load  = 1'b1;
          cnt_value = L_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          cnt_load  = 1'b1;
          // lcd_rs/lcd_dat double as the latched byte.
          cnt_value = is_long_cmd(lcd_rs, lcd_dat) ? L_CLEAR : L_EXEC;
        end
      end
      default: begin
        cnt_load  = 1'b0;
        cnt_value = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_PWRUP;
      in_ready <= 1'b0;
      busy     <= 1'b1;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_dat  <= 8'h00;
    end else begin
      case (state)
        ST_PWRUP: begin
          if (cnt_done) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        ST_IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is a transfer.
          if (in_valid) begin
            lcd_rs   <= in_rs;
            lcd_dat  <= in_data;
            state    <= ST_SETUP;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (cnt_done) begin
            state  <= ST_PULSE;
            lcd_en <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_done) begin
            state  <= ST_HOLD;
            lcd_en <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (cnt_done) begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_done) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= ST_PWRUP;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          lcd_en   <= 1'b0;
        end
      endcase
    end
  end

  assign lcd_rw = 1'b0;

endmodule
